// File: rtl/video_pkg.sv
// 720p60 timing constants, RGB pixel type and colour constants shared by the video mixer.
// No logic, no latency; no backpressure.
package video_pkg;

    localparam int HRES_720  = 1280;
    localparam int HFP_720   = 110;
    localparam int HSW_720   = 40;
    localparam int HBP_720   = 220;
    localparam int HTOTAL_720 = HRES_720 + HFP_720 + HSW_720 + HBP_720;

    localparam int VRES_720  = 720;
    localparam int VFP_720   = 5;
    localparam int VSW_720   = 5;
    localparam int VBP_720   = 20;
    localparam int VTOTAL_720 = VRES_720 + VFP_720 + VSW_720 + VBP_720;

    typedef logic [2:0][7:0] rgb_t;

    localparam rgb_t BG_RGB      = 24'h000000;
    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_mixer_layer_mixer.sv
// Fixed-priority layer select: lowest-index active layer wins, background otherwise.
// Purely combinational (0 cycles); no backpressure.
module layer_mixer
    import video_pkg::*;
#(
    parameter int   NUM_LAYERS = 4,
    parameter rgb_t BG_COLOR   = BG_RGB
) (
    input  logic [NUM_LAYERS-1:0][2:0][7:0] layer_pixel,
    input  logic [NUM_LAYERS-1:0]           layer_active,
    output logic [2:0][7:0]                 pixel
);

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        pixel = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_active[i]) begin
                pixel = layer_pixel[i];
            end
        end
    end

endmodule

// File: rtl/video_timing_mixer.sv
// Raster timing source plus registered priority mixer for the HDMI encoder; VTM_TPG_EN adds colour bars.
// Latency: hpos/vpos/fsync combinational from counters, rgb/hsync/vsync/de one pixel_clk later.
// No backpressure: free-running raster, objects must answer within the same cycle.
module video_timing_mixer
    import video_pkg::*;
#(
    parameter int   HRES       = HRES_720,
    parameter int   HFP        = HFP_720,
    parameter int   HSW        = HSW_720,
    parameter int   HBP        = HBP_720,
    parameter int   VRES       = VRES_720,
    parameter int   VFP        = VFP_720,
    parameter int   VSW        = VSW_720,
    parameter int   VBP        = VBP_720,
    parameter logic SYNC_POL   = 1'b1,
    parameter int   NUM_LAYERS = 4,
    parameter rgb_t BG_COLOR   = BG_RGB
) (
    input  logic                           pixel_clk,
    input  logic                           rst,
    output logic signed [11:0]             hpos,
    output logic signed [11:0]             vpos,
    output logic                           fsync,
    input  logic [NUM_LAYERS-1:0][2:0][7:0] layer_pixel,
    input  logic [NUM_LAYERS-1:0]          layer_active,
    input  logic                           tpg_en,
    output logic [2:0][7:0]                rgb,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           de,
    output logic [15:0]                    frame_cnt
);

    localparam int HTOTAL = HRES + HFP + HSW + HBP;
    localparam int VTOTAL = VRES + VFP + VSW + VBP;

    logic [11:0]     hcnt;
    logic [11:0]     vcnt;
    logic            hs_raw;
    logic            vs_raw;
    logic            de_raw;
    logic [2:0][7:0] mix_pix;
    logic [2:0][7:0] next_pix;

    assign hpos   = signed'(hcnt);
    assign vpos   = signed'(vcnt);
    // Strobe on the first blanking line so objects move while nothing is displayed.
    assign fsync  = (hcnt == 12'd0) && (vcnt == 12'(VRES));
    assign hs_raw = (hcnt >= 12'(HRES + HFP)) && (hcnt < 12'(HRES + HFP + HSW));
    assign vs_raw = (vcnt >= 12'(VRES + VFP)) && (vcnt < 12'(VRES + VFP + VSW));
    assign de_raw = (hcnt < 12'(HRES)) && (vcnt < 12'(VRES));

    layer_mixer #(
        .NUM_LAYERS (NUM_LAYERS),
        .BG_COLOR   (BG_COLOR)
    ) u_mixer (
        .layer_pixel  (layer_pixel),
        .layer_active (layer_active),
        .pixel        (mix_pix)
    );

`ifdef VTM_TPG_EN
    logic [2:0] bar_idx;
    assign bar_idx  = 3'(hcnt / 12'(HRES / 8));
    assign next_pix = tpg_en ? bar_color(bar_idx) : mix_pix;
`else
    logic tpg_unused;
    assign tpg_unused = tpg_en;
    assign next_pix   = mix_pix;
`endif

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hcnt      <= 12'd0;
            vcnt      <= 12'd0;
            frame_cnt <= 16'd0;
            rgb       <= '0;
            de        <= 1'b0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
        end else begin
            if (hcnt == 12'(HTOTAL - 1)) begin
                hcnt <= 12'd0;
                vcnt <= (vcnt == 12'(VTOTAL - 1)) ? 12'd0 : vcnt + 12'd1;
            end else begin
                hcnt <= hcnt + 12'd1;
            end
            if (fsync) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            rgb   <= de_raw ? next_pix : '0;
            de    <= de_raw;
            hsync <= hs_raw ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_raw ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_video_timing_mixer.sv
// Directed bench: full 720p instance for line-level behaviour, a shrunken-raster instance for frame-level behaviour.
module tb_video_timing_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, rst_s, tpg_en;
    logic [3:0][2:0][7:0]   layer_pixel;
    logic [3:0]             layer_active;

    logic signed [11:0] hpos, vpos, hpos_s, vpos_s;
    logic               fsync, fsync_s;
    logic [2:0][7:0]    rgb, rgb_s;
    logic               hsync, vsync, de, hsync_s, vsync_s, de_s;
    logic [15:0]        frame_cnt, frame_cnt_s;

    int checks = 0;
    int errors = 0;

    video_timing_mixer dut (
        .pixel_clk    (clk),
        .rst          (rst),
        .hpos         (hpos),
        .vpos         (vpos),
        .fsync        (fsync),
        .layer_pixel  (layer_pixel),
        .layer_active (layer_active),
        .tpg_en       (tpg_en),
        .rgb          (rgb),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .frame_cnt    (frame_cnt)
    );

    // 24 x 13 raster: 16x8 active, hsync cols 18..20, vsync lines 9..10, 312 cycles/frame.
    video_timing_mixer #(
        .HRES(16), .HFP(2), .HSW(3), .HBP(3),
        .VRES(8),  .VFP(1), .VSW(2), .VBP(2)
    ) dut_s (
        .pixel_clk    (clk),
        .rst          (rst_s),
        .hpos         (hpos_s),
        .vpos         (vpos_s),
        .fsync        (fsync_s),
        .layer_pixel  (layer_pixel),
        .layer_active (layer_active),
        .tpg_en       (tpg_en),
        .rgb          (rgb_s),
        .hsync        (hsync_s),
        .vsync        (vsync_s),
        .de           (de_s),
        .frame_cnt    (frame_cnt_s)
    );

    typedef struct {
        logic [3:0]  act;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_d(input int h, input int v, input string nm);
        int n = 0;
        while (!(int'(hpos) == h && int'(vpos) == v) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for (%0d,%0d)", nm, h, v);
        end
    endtask

    task automatic wait_s(input int h, input int v, input string nm);
        int n = 0;
        while (!(int'(hpos_s) == h && int'(vpos_s) == v) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for (%0d,%0d)", nm, h, v);
        end
    endtask

    initial begin
        int n, d, vs, f0, vs_h, vs_v;
        bit seen;

        vecs[0] = '{4'b0110, 24'hEFE62E};
        vecs[1] = '{4'b0000, 24'h000000};
        vecs[2] = '{4'b1111, 24'h112233};
        vecs[3] = '{4'b1000, 24'h0A0B0C};
        vecs[4] = '{4'b1100, 24'hFF0000};
        vecs[5] = '{4'b0001, 24'h112233};

        rst          = 1'b1;
        rst_s        = 1'b1;
        tpg_en       = 1'b0;
        layer_active = 4'b0000;
        layer_pixel  = {24'h0A0B0C, 24'hFF0000, 24'hEFE62E, 24'h112233};
        repeat (5) tick();

        chk("rst_hpos", hpos, 0);
        chk("rst_vpos", vpos, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_de", de, 0);
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_fsync", fsync, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        rst   = 1'b0;
        rst_s = 1'b0;
        chk("first_hpos", hpos, 0);
        chk("first_vpos", vpos, 0);

        for (int i = 0; i < 6; i++) begin
            layer_active = vecs[i].act;
            tick();
            chk($sformatf("prio_rgb_%0d", i), rgb, vecs[i].exp);
            chk($sformatf("prio_de_%0d", i), de, 1);
        end
        layer_active = 4'b0000;

        wait_d(1300, 0, "wait_blank");
        layer_active = 4'b0001;
        tick();
        chk("blank_rgb", rgb, 0);
        chk("blank_de", de, 0);
        layer_active = 4'b0000;

        wait_d(1390, 0, "wait_hs");
        chk("hsync_pre", hsync, 0);
        n = 0;
        tick();
        while (hsync === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("hsync_width", n, 40);
        chk("hsync_end_col", hpos, 1431);

        wait_d(1649, 0, "wait_wrap");
        tick();
        chk("wrap_hpos", hpos, 0);
        chk("wrap_vpos", vpos, 1);

        d = 0;
        for (int i = 0; i < 1650; i++) begin
            d += int'(de);
            tick();
        end
        chk("de_per_line", d, 1280);
        chk("line2_vpos", vpos, 2);

`ifdef VTM_TPG_EN
        wait_d(0, 2, "wait_tpg");
        tpg_en       = 1'b1;
        layer_active = 4'b0001;
        tick();
        chk("tpg_x0", rgb, 24'hFFFFFF);
        wait_d(160, 2, "wait_tpg160");
        tick();
        chk("tpg_x160", rgb, 24'hFFFF00);
        wait_d(1279, 2, "wait_tpg1279");
        tick();
        chk("tpg_x1279", rgb, 24'h000000);
        tpg_en       = 1'b0;
        layer_active = 4'b0000;
`else
        wait_d(0, 2, "wait_tpg");
        tpg_en       = 1'b1;
        layer_active = 4'b0001;
        tick();
        chk("tpg_ignored", rgb, 24'h112233);
        tpg_en       = 1'b0;
        layer_active = 4'b0000;
`endif

        wait_d(640, 3, "wait_midrst");
        layer_active = 4'b0001;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        layer_active = 4'b0000;
        chk("mid_hpos", hpos, 0);
        chk("mid_vpos", vpos, 0);
        chk("mid_rgb", rgb, 0);
        chk("mid_de", de, 0);
        chk("mid_hsync", hsync, 0);
        chk("mid_vsync", vsync, 0);
        chk("mid_frame_cnt", frame_cnt, 0);
        tick();
        chk("mid_next_hpos", hpos, 1);

        // Frame-level behaviour on the shrunken raster.
        n = 0;
        while (fsync_s !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk("s_fsync_found", n < 1000, 1);
        chk("s_fsync_h", hpos_s, 0);
        chk("s_fsync_v", vpos_s, 8);
        f0   = int'(frame_cnt_s);
        n    = 0;
        d    = 0;
        vs   = 0;
        seen = 1'b0;
        vs_h = -1;
        vs_v = -1;
        tick();
        n++;
        while (fsync_s !== 1'b1 && n < 1000) begin
            d  += int'(de_s);
            vs += int'(vsync_s);
            if (vsync_s && !seen) begin
                seen = 1'b1;
                vs_h = int'(hpos_s);
                vs_v = int'(vpos_s);
            end
            tick();
            n++;
        end
        d  += int'(de_s);
        vs += int'(vsync_s);
        chk("s_frame_period", n, 312);
        chk("s_de_per_frame", d, 128);
        chk("s_vsync_cycles", vs, 48);
        chk("s_vsync_rise_h", vs_h, 1);
        chk("s_vsync_rise_v", vs_v, 9);
        chk("s_frame_inc", frame_cnt_s, 16'(f0 + 1));

        wait_s(8, 4, "wait_s_midrst");
        layer_active = 4'b0001;
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        layer_active = 4'b0000;
        chk("s_mid_hpos", hpos_s, 0);
        chk("s_mid_vpos", vpos_s, 0);
        chk("s_mid_rgb", rgb_s, 0);
        chk("s_mid_de", de_s, 0);
        chk("s_mid_frame_cnt", frame_cnt_s, 0);
        n = 0;
        while (fsync_s !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk("s_rst_to_fsync", n, 192);
        chk("s_first_frame_cnt", frame_cnt_s, 0);
        tick();
        chk("s_first_frame_inc", frame_cnt_s, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
